// File: rtl/mu0_mem_arbiter_if.sv
// Bus bundle between the MU0 core, the loader/debug port and the shared memory.
// The arbiter uses the slave modport; the surrounding system uses master.
interface mu0_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_wait;

  logic              ld_req;
  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_ack;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              owner_ld;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  ld_req, ld_wr, ld_addr, ld_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_wait,
    output ld_rdata, ld_ack,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output owner_ld
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output ld_req, ld_wr, ld_addr, ld_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_wait,
    input  ld_rdata, ld_ack,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  owner_ld
  );
endinterface

// File: rtl/mu0_mem_arbiter.sv
// Two-requester memory arbiter: MU0 core vs. loader/debug port, round-robin on ties,
// fixed WAIT-cycle memory accesses with latched address/data/direction.
module mu0_mem_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WAIT   = 2
) (
  input logic              Clk,
  input logic              Reset,
  mu0_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    LD_ACC
  } state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_LD
  } owner_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  state_e            state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              ld_ack_q, ld_ack_d;

  logic cpu_req;
  logic ld_valid;
  logic final_cyc;
  logic cpu_final;
  logic grant_cpu;
  logic grant_ld;

  assign cpu_req   = bus.cpu_rd | bus.cpu_wr;
  // The loader still holds ld_req while its ack is out; that is not a new request.
  assign ld_valid  = bus.ld_req & ~ld_ack_q;
  assign final_cyc = (cnt_q == '0);
  assign cpu_final = (state_q == CPU_ACC) && final_cyc;

  always_comb begin
    grant_cpu = 1'b0;
    grant_ld  = 1'b0;
    if (state_q == IDLE) begin
      if (cpu_req && ld_valid) begin
        if (last_owner_q == OWN_CPU) grant_ld  = 1'b1;
        else                         grant_cpu = 1'b1;
      end else if (ld_valid) begin
        grant_ld = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ld_rdata_d   = ld_rdata_q;
    ld_ack_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          state_d      = CPU_ACC;
          last_owner_d = OWN_CPU;
          cnt_d        = CNT_INIT;
          mem_addr_d   = bus.cpu_addr;
          mem_wdata_d  = bus.cpu_wdata;
          mem_wr_d     = bus.cpu_wr;
          mem_rd_d     = ~bus.cpu_wr;
        end else if (grant_ld) begin
          state_d      = LD_ACC;
          last_owner_d = OWN_LD;
          cnt_d        = CNT_INIT;
          mem_addr_d   = bus.ld_addr;
          mem_wdata_d  = bus.ld_wdata;
          mem_wr_d     = bus.ld_wr;
          mem_rd_d     = ~bus.ld_wr;
        end
      end

      CPU_ACC: begin
        if (final_cyc) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (mem_rd_q) cpu_rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      LD_ACC: begin
        if (final_cyc) begin
          state_d  = IDLE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          ld_ack_d = 1'b1;
          if (mem_rd_q) ld_rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_CPU;
      cnt_q        <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
      ld_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
      ld_ack_q     <= ld_ack_d;
    end
  end

  // The core sees read data combinationally in its last cycle so it can proceed without a bubble.
  assign bus.cpu_rdata = cpu_final ? bus.mem_rdata : cpu_rdata_q;
  assign bus.cpu_wait  = cpu_req & ~cpu_final;
  assign bus.ld_rdata  = ld_rdata_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.owner_ld  = (state_q == LD_ACC);

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Bench for mu0_mem_arbiter: transaction-level reference (memory image, grant order,
// 1+WAIT timing rule) checked against a WAIT=2 instance and a WAIT=1 instance.
module tb_mu0_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam int          W  = 2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  mu0_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b  ();
  mu0_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  mu0_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b)
  );

  mu0_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT(1)) dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (b1)
  );

  // Memory attached to the WAIT=2 instance, with a clear and a backdoor preload port.
  logic [15:0] mem [0:255];
  logic        mem_clr;
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [15:0] bd_data;

  always @(posedge Clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (b.mem_wr) begin
      mem[b.mem_addr[7:0]] <= b.mem_wdata;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end
  end
  assign b.mem_rdata  = mem[b.mem_addr[7:0]];
  assign b1.mem_rdata = {4'h0, b1.mem_addr} ^ 16'h5A5A;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] ref_mem [0:255];
  bit          last_ld;
  logic [15:0] last_ld_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One arbitration round starting from IDLE: either or both requesters raise a request
  // in cycle 0. A grant at IDLE cycle g gives strobes in g+1..g+W, CPU done at g+W,
  // loader ack at g+W+1; a loser is granted in IDLE cycle W+1.
  task automatic run_pair(input string tag, input bit do_cpu, input bit do_ld,
                          input logic c_rd, input logic c_wr,
                          input logic [11:0] c_addr, input logic [15:0] c_wd,
                          input logic l_wr, input logic [11:0] l_addr,
                          input logic [15:0] l_wd);
    int          g_cpu, g_ld, c_done, l_done, k_end;
    bit          ld_first;
    logic [15:0] exp_c, exp_l;
    ld_first = do_ld && (!do_cpu || !last_ld);
    g_cpu    = (do_cpu && do_ld && ld_first)  ? W + 1 : 0;
    g_ld     = (do_cpu && do_ld && !ld_first) ? W + 1 : 0;
    c_done   = g_cpu + W;
    l_done   = g_ld + W + 1;
    exp_c    = 16'h0;
    exp_l    = last_ld_rdata;
    for (int s = 0; s < 2; s++) begin
      if (((s == 0) == ld_first) && do_ld) begin
        if (l_wr) ref_mem[l_addr[7:0]] = l_wd;
        else      exp_l = ref_mem[l_addr[7:0]];
      end else if (((s == 0) != ld_first) && do_cpu) begin
        if (c_wr) ref_mem[c_addr[7:0]] = c_wd;
        else      exp_c = ref_mem[c_addr[7:0]];
      end
    end
    last_ld       = (do_cpu && do_ld) ? !ld_first : do_ld;
    last_ld_rdata = exp_l;
    k_end = ((do_cpu && c_done > (do_ld ? l_done : 0)) ? c_done : (do_ld ? l_done : c_done)) + 1;

    for (int k = 0; k <= k_end; k++) begin
      bit cpu_on, ld_on, in_c, in_l;
      @(negedge Clk);
      cpu_on      = do_cpu && (k <= c_done);
      ld_on       = do_ld && (k <= l_done);
      b.cpu_rd    = cpu_on && c_rd;
      b.cpu_wr    = cpu_on && c_wr;
      b.cpu_addr  = c_addr;
      b.cpu_wdata = c_wd;
      b.ld_req    = ld_on;
      b.ld_wr     = l_wr;
      b.ld_addr   = l_addr;
      b.ld_wdata  = l_wd;
      #1;
      in_c = do_cpu && (k > g_cpu) && (k <= c_done);
      in_l = do_ld && (k > g_ld) && (k <= g_ld + W);
      chk({tag, ".cpu_wait"}, 32'(b.cpu_wait), 32'(cpu_on && (k != c_done)));
      chk({tag, ".mem_rd"},   32'(b.mem_rd),   32'((in_c && !c_wr) || (in_l && !l_wr)));
      chk({tag, ".mem_wr"},   32'(b.mem_wr),   32'((in_c && c_wr) || (in_l && l_wr)));
      chk({tag, ".owner_ld"}, 32'(b.owner_ld), 32'(in_l));
      chk({tag, ".ld_ack"},   32'(b.ld_ack),   32'(do_ld && (k == l_done)));
      if (in_c) begin
        chk({tag, ".cpu_addr"}, 32'(b.mem_addr), 32'(c_addr));
        if (c_wr) chk({tag, ".cpu_wdata"}, 32'(b.mem_wdata), 32'(c_wd));
      end
      if (in_l) begin
        chk({tag, ".ld_addr"}, 32'(b.mem_addr), 32'(l_addr));
        if (l_wr) chk({tag, ".ld_wdata"}, 32'(b.mem_wdata), 32'(l_wd));
      end
      if (do_cpu && (k == c_done) && !c_wr) chk({tag, ".cpu_rdata"}, 32'(b.cpu_rdata), 32'(exp_c));
      if (do_ld && (k == l_done))           chk({tag, ".ld_rdata"},  32'(b.ld_rdata),  32'(exp_l));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a1;
    Reset = 1'b1;
    b.cpu_rd = 1'b0; b.cpu_wr = 1'b0; b.cpu_addr = '0; b.cpu_wdata = '0;
    b.ld_req = 1'b0; b.ld_wr = 1'b0;  b.ld_addr = '0;  b.ld_wdata = '0;
    b1.cpu_rd = 1'b0; b1.cpu_wr = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.ld_req = 1'b0; b1.ld_wr = 1'b0;  b1.ld_addr = '0;  b1.ld_wdata = '0;
    mem_clr = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
    last_ld = 1'b0;
    last_ld_rdata = 16'h0;

    @(negedge Clk);
    mem_clr = 1'b0; bd_we = 1'b1; bd_addr = 8'h05; bd_data = 16'h1234;
    ref_mem[8'h05] = 16'h1234;
    @(negedge Clk);
    bd_we = 1'b0;
    #1;
    chk("rst.mem_rd",    32'(b.mem_rd),    32'h0);
    chk("rst.mem_wr",    32'(b.mem_wr),    32'h0);
    chk("rst.ld_ack",    32'(b.ld_ack),    32'h0);
    chk("rst.owner_ld",  32'(b.owner_ld),  32'h0);
    chk("rst.cpu_rdata", 32'(b.cpu_rdata), 32'h0);
    chk("rst.ld_rdata",  32'(b.ld_rdata),  32'h0);
    chk("rst.mem_addr",  32'(b.mem_addr),  32'h0);
    chk("rst.mem_wdata", 32'(b.mem_wdata), 32'h0);
    chk("rst.cpu_wait",  32'(b.cpu_wait),  32'h0);
    Reset = 1'b0;

    run_pair("cpu_rd5",   1, 0, 1, 0, 12'h005, 16'h0000, 0, 12'h000, 16'h0000);
    run_pair("ld_wrFF",   0, 1, 0, 0, 12'h000, 16'h0000, 1, 12'h0FF, 16'hBEEF);
    run_pair("cpu_rbFF",  1, 0, 1, 0, 12'h0FF, 16'h0000, 0, 12'h000, 16'h0000);
    run_pair("cpu_rdwr",  1, 0, 1, 1, 12'h010, 16'h0042, 0, 12'h000, 16'h0000);
    run_pair("cpu_rb10",  1, 0, 1, 0, 12'h010, 16'h0000, 0, 12'h000, 16'h0000);
    run_pair("ld_rd5",    0, 1, 0, 0, 12'h000, 16'h0000, 0, 12'h005, 16'h0000);

    // Reset in the first LD_ACC cycle (counter 1) of a loader write.
    @(negedge Clk);
    b.ld_req = 1'b1; b.ld_wr = 1'b1; b.ld_addr = 12'h0AA; b.ld_wdata = 16'hDEAD;
    @(negedge Clk);
    #1;
    chk("abort.pre_wr",    32'(b.mem_wr),   32'h1);
    chk("abort.pre_owner", 32'(b.owner_ld), 32'h1);
    Reset = 1'b1;
    #1;
    chk("abort.mem_wr",   32'(b.mem_wr),   32'h0);
    chk("abort.owner_ld", 32'(b.owner_ld), 32'h0);
    chk("abort.ld_ack",   32'(b.ld_ack),   32'h0);
    chk("abort.ld_rdata", 32'(b.ld_rdata), 32'h0);
    @(negedge Clk);
    b.ld_req = 1'b0; b.ld_wr = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    last_ld = 1'b0;
    last_ld_rdata = 16'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      #1;
      chk("abort.no_ack", 32'(b.ld_ack), 32'h0);
      chk("abort.idle_wr", 32'(b.mem_wr), 32'h0);
    end

    run_pair("tie1", 1, 1, 1, 0, 12'h0FF, 16'h0000, 0, 12'h010, 16'h0000);
    run_pair("tie2", 1, 1, 0, 1, 12'h020, 16'h7777, 1, 12'h021, 16'h8888);
    run_pair("tie3", 1, 1, 1, 0, 12'h021, 16'h0000, 0, 12'h020, 16'h0000);

    for (int n = 0; n < 24; n++) begin
      int unsigned sel, cop;
      sel = $urandom_range(1, 3);
      cop = $urandom_range(0, 2);
      run_pair("rand", sel[0], sel[1], cop != 1, cop != 0,
               12'($urandom_range(0, 31)), 16'($urandom),
               1'($urandom_range(0, 1)), 12'($urandom_range(0, 31)), 16'($urandom));
    end

    a1 = 12'h000;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      b1.cpu_rd = 1'b1;
      if (k % 2 == 0) begin
        a1 = 12'(k * 3 + 1);
        b1.cpu_addr = a1;
      end
      #1;
      chk("w1.cpu_wait", 32'(b1.cpu_wait), 32'(k % 2 == 0));
      chk("w1.mem_rd",   32'(b1.mem_rd),   32'(k % 2 == 1));
      if (k % 2 == 1) chk("w1.cpu_rdata", 32'(b1.cpu_rdata), 32'({4'h0, a1} ^ 16'h5A5A));
    end
    @(negedge Clk);
    b1.cpu_rd = 1'b0;

    @(negedge Clk);
    for (int a = 0; a < 256; a++) chk("mem_image", 32'(mem[a]), 32'(ref_mem[a]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mu0_mem_arbiter.md
MU0_MEM_ARBITER -- requirements
Module: mu0_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  ADDR_W, 12, address width
  DATA_W, 16, data width
  WAIT, 2, memory cycles per access (legal 1..15)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning:
  Clk  input  1  system clock, rising edge
  Reset  input  1  system reset, asynchronous, active-high
  cpu_rd  input  1  MU0 memory read request
  cpu_wr  input  1  MU0 memory write request
  cpu_addr  input  ADDR_W  MU0 address
  cpu_wdata  input  DATA_W  MU0 write data
  cpu_rdata  output  DATA_W  read data to MU0
  cpu_wait  output  1  stall MU0; access not complete
  ld_req  input  1  loader/debug access request, level
  ld_wr  input  1  loader access is a write (1) or a read (0)
  ld_addr  input  ADDR_W  loader address
  ld_wdata  input  DATA_W  loader write data
  ld_rdata  output  DATA_W  registered loader read data
  ld_ack  output  1  loader access done, one-cycle pulse
  mem_rd  output  1  memory read strobe
  mem_wr  output  1  memory write strobe
  mem_addr  output  ADDR_W  memory address
  mem_wdata  output  DATA_W  memory write data
  mem_rdata  input  DATA_W  memory read data, valid in the final access cycle
  owner_ld  output  1  current access belongs to the loader

Function
REQ-003 The FSM SHALL have three states: IDLE, CPU_ACC and LD_ACC.
REQ-004 Arbitration SHALL take place only in IDLE.
REQ-005 In IDLE with a CPU request (cpu_rd or cpu_wr) only, the next state SHALL be CPU_ACC.
REQ-006 In IDLE with a valid loader request only, the next state SHALL be LD_ACC.
REQ-007 A loader request SHALL be valid when ld_req is high and ld_ack is low.
REQ-008 In IDLE with both requests, the grant SHALL go to the requester that did not own the previous access (last_owner register, round-robin).
REQ-009 When an access is granted, the requester's address, write data and direction SHALL be latched and held on mem_addr, mem_wdata, mem_rd and mem_wr for the whole access.
REQ-010 If cpu_rd and cpu_wr are both high, the CPU access SHALL be a write.
REQ-011 On entry to an access state, a 4-bit counter SHALL load WAIT-1.
REQ-012 The counter SHALL decrement each cycle; the cycle in which count is 0 is the final access cycle.
REQ-013 Each access SHALL last exactly WAIT cycles with the strobe high, then return to IDLE.
REQ-014 In IDLE, mem_rd and mem_wr SHALL be 0, and mem_addr and mem_wdata SHALL hold their last values.
REQ-015 cpu_wait SHALL be combinational: 1 when a CPU request is present, except in the final CPU_ACC cycle, where it SHALL be 0.
REQ-016 In the final CPU_ACC cycle, cpu_rdata SHALL equal mem_rdata; otherwise cpu_rdata SHALL hold the last captured value.
REQ-017 At the end of the final LD_ACC cycle, ld_rdata SHALL capture mem_rdata (reads only), and ld_ack SHALL pulse high for the following cycle.
REQ-018 The loader SHALL hold ld_req and ld_* stable until ld_ack, and the arbiter SHALL ignore ld_req during the ld_ack cycle.
REQ-019 A CPU request has a minimum latency of 1 + WAIT cycles: one IDLE cycle plus the access.
REQ-020 A loader request has a latency of 1 + WAIT cycles to ld_ack plus 1 cycle, with no contention.
REQ-021 owner_ld SHALL be 1 only in LD_ACC.
REQ-022 last_owner SHALL update on each grant.
REQ-023 Requests arriving during an access SHALL wait; no request is lost or truncated.

Reset
REQ-024 Reset high SHALL force the following immediately, regardless of Clk:
  state to IDLE
  counter to 0
  mem_rd, mem_wr, ld_ack and owner_ld to 0
  cpu_rdata, ld_rdata, mem_addr and mem_wdata to 0
  last_owner to CPU, so the loader wins the first tie
REQ-025 A reset during an access SHALL abort it with no ld_ack.
REQ-026 After reset release, arbitration SHALL restart from IDLE on the next rising edge.

Verification
REQ-027 CPU read, WAIT=2: cpu_rd=1 with cpu_addr=0x005, memory word 0x1234.
  Required: mem_rd high for 2 cycles; cpu_wait 1,1,0; cpu_rdata=0x1234 in the final cycle.
REQ-028 Loader write: ld_req=1, ld_wr=1, ld_addr=0x0FF, ld_wdata=0xBEEF.
  Required: mem_wr for 2 cycles at 0x0FF; ld_ack one pulse; a readback via the CPU returns 0xBEEF.
REQ-029 Simultaneous requests after reset: cpu_rd and ld_req both asserted.
  Required: loader served first; CPU served next with cpu_wait held meanwhile.
  Required: with both still requesting, grants alternate LD, CPU, LD, CPU.
REQ-030 CPU cpu_rd and cpu_wr both high, addr 0x010, wdata 0x0042.
  Required: write performed (mem_wr=1, mem_rd=0) and memory[0x010]=0x0042.
REQ-031 Reset mid LD_ACC (counter=1): Reset pulse.
  Required: mem_wr drops without waiting for Clk; no ld_ack; state IDLE; ld_rdata=0.
REQ-032 WAIT=1 back-to-back CPU requests.
  Required: each access takes 2 cycles (IDLE plus one CPU_ACC); cpu_wait pattern 1,0 repeating.
